// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute handshake bundle for the ALU issue stage.
// master = surrounding pipeline (decode + execute), slave = the issue stage.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    // Decode side
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_rs_val;
    logic [DATA_W-1:0] in_rt_val;
    logic [15:0]       in_imm;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [PC_W-1:0]   in_pc;
    logic              flush;

    // Execute side
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_op;
    logic              ex_sub;
    logic              ex_ov_en;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [4:0]        ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_branch_ne;
    logic              ex_illegal;
    logic [PC_W-1:0]   ex_pc;

    modport master (
        output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
               in_rt, in_rd, in_pc, flush, ex_ready,
        input  in_ready, ex_valid, ex_op, ex_sub, ex_ov_en, ex_a, ex_b, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne,
               ex_illegal, ex_pc
    );

    modport slave (
        input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
               in_rt, in_rd, in_pc, flush, ex_ready,
        output in_ready, ex_valid, ex_op, ex_sub, ex_ov_en, ex_a, ex_b, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne,
               ex_illegal, ex_pc
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes opcode/funct into ALU controls, selects the B
// operand and holds one instruction for execute behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef struct packed {
        alu_op_e           op;
        logic              sub;
        logic              ov_en;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              branch_ne;
        logic              illegal;
        logic [PC_W-1:0]   pc;
    } payload_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    payload_t          dec;
    payload_t          q;
    logic              ex_valid_q;
    logic              load;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    assign imm_sext = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, bus.in_imm};

    // Single-entry register: free when empty or being drained this cycle.
    assign bus.in_ready = !ex_valid_q || bus.ex_ready;
    assign load         = bus.in_valid && bus.in_ready;

    // Translate opcode/funct into ALU controls and operand selection.
    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        dec       = '0;
        dec.op    = ALU_ADD;
        dec.a     = bus.in_rs_val;
        dec.b     = bus.in_rt_val;
        dec.dest  = bus.in_rt;
        dec.pc    = bus.in_pc;
        unique case (bus.in_opcode)
            OP_RTYPE: begin
                dec.dest      = bus.in_rd;
                dec.reg_write = 1'b1;
                unique case (bus.in_funct)
                    FN_ADD:  dec.ov_en = 1'b1;
                    FN_ADDU: dec.op    = ALU_ADD;
                    FN_SUB:  begin dec.op = ALU_SUB; dec.sub = 1'b1; dec.ov_en = 1'b1; end
                    FN_SUBU: begin dec.op = ALU_SUB; dec.sub = 1'b1; end
                    FN_AND:  dec.op    = ALU_AND;
                    FN_OR:   dec.op    = ALU_OR;
                    FN_NOR:  dec.op    = ALU_NOR;
                    FN_SLT:  begin dec.op = ALU_SLT; dec.sub = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dec.b = imm_sext; dec.ov_en = 1'b1; dec.reg_write = 1'b1; end
            OP_ADDIU: begin dec.b = imm_sext; dec.reg_write = 1'b1; end
            OP_SLTI:  begin dec.b = imm_sext; dec.op = ALU_SLT; dec.sub = 1'b1; dec.reg_write = 1'b1; end
            OP_ANDI:  begin dec.b = imm_zext; dec.op = ALU_AND; dec.reg_write = 1'b1; end
            OP_ORI:   begin dec.b = imm_zext; dec.op = ALU_OR;  dec.reg_write = 1'b1; end
            OP_LW:    begin dec.b = imm_sext; dec.mem_read = 1'b1; dec.reg_write = 1'b1; end
            OP_SW:    begin dec.b = imm_sext; dec.mem_write = 1'b1; end
            OP_BEQ:   begin dec.op = ALU_SUB; dec.sub = 1'b1; dec.branch = 1'b1; end
            OP_BNE:   begin dec.op = ALU_SUB; dec.sub = 1'b1; dec.branch = 1'b1; dec.branch_ne = 1'b1; end
            default:  dec.illegal = 1'b1;
        endcase
        // Unsupported encodings become a harmless ADD with no side effects.
        if (dec.illegal) begin
            dec.op        = ALU_ADD;
            dec.sub       = 1'b0;
            dec.ov_en     = 1'b0;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.branch_ne = 1'b0;
        end
    end

    // Valid flag: flush wins, then load, then drain by execute.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q <= 1'b0;
        end else if (load) begin
            ex_valid_q <= 1'b1;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Payload register: captured on load, otherwise held for a stalled consumer.
    // NOTE: payload is reset too, because reset values are visible on ex_* outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            q.op <= ALU_ADD;
        end else if (load) begin
            q <= dec;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_op        = q.op;
    assign bus.ex_sub       = q.sub;
    assign bus.ex_ov_en     = q.ov_en;
    assign bus.ex_a         = q.a;
    assign bus.ex_b         = q.b;
    assign bus.ex_dest      = q.dest;
    assign bus.ex_reg_write = q.reg_write;
    assign bus.ex_mem_read  = q.mem_read;
    assign bus.ex_mem_write = q.mem_write;
    assign bus.ex_branch    = q.branch;
    assign bus.ex_branch_ne = q.branch_ne;
    assign bus.ex_illegal   = q.illegal;
    assign bus.ex_pc        = q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, immediates, backpressure,
// flush and asynchronous reset, with hand-computed expectations.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_issue_stage_if #(.DATA_W(32), .PC_W(32)) bus ();

    alu_issue_stage #(.DATA_W(32), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // {reg_write, mem_read, mem_write, branch, branch_ne}
    function automatic logic [31:0] ctrl();
        return {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_branch, bus.ex_branch_ne};
    endfunction

    task automatic set_instr(input logic [5:0] opcode, input logic [5:0] funct,
                             input logic [31:0] rs_val, input logic [31:0] rt_val,
                             input logic [15:0] imm, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] pc);
        bus.in_opcode = opcode;
        bus.in_funct  = funct;
        bus.in_rs_val = rs_val;
        bus.in_rt_val = rt_val;
        bus.in_imm    = imm;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_pc     = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present the current instruction for one edge (ex_ready assumed high).
    task automatic issue();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    localparam logic [31:0] PC_BASE = 32'h100;

    int sent;
    int got;
    int stall_left;
    int stall_seen;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        set_instr(6'h00, 6'h20, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", bus.ex_valid, 0);
        check("rst_op", bus.ex_op, 4'b0010);
        check("rst_ctrl", ctrl(), 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        // R-type sub
        set_instr(6'h00, 6'h22, 7, 3, 16'h0, 5'd3, 5'd9, 32'h10);
        issue();
        check("sub_valid", bus.ex_valid, 1);
        check("sub_op", bus.ex_op, 4'b0110);
        check("sub_sub", bus.ex_sub, 1);
        check("sub_ov", bus.ex_ov_en, 1);
        check("sub_a", bus.ex_a, 7);
        check("sub_b", bus.ex_b, 3);
        check("sub_dest", bus.ex_dest, 9);
        check("sub_ctrl", ctrl(), 5'b10000);
        check("sub_pc", bus.ex_pc, 32'h10);

        // R-type nor, slt
        set_instr(6'h00, 6'h27, 32'hF0F0_0000, 32'h0000_FFFF, 16'h0, 5'd4, 5'd5, 32'h14);
        issue();
        check("nor_op", bus.ex_op, 4'b1100);
        check("nor_sub", bus.ex_sub, 0);
        set_instr(6'h00, 6'h2A, 1, 2, 16'h0, 5'd4, 5'd6, 32'h18);
        issue();
        check("slt_op", bus.ex_op, 4'b0111);
        check("slt_sub", bus.ex_sub, 1);
        check("slt_ov", bus.ex_ov_en, 0);
        check("slt_dest", bus.ex_dest, 6);

        // andi zero-extends
        set_instr(6'h0C, 6'h3F, 32'h55, 32'hDEAD, 16'h8001, 5'd11, 5'd30, 32'h1C);
        issue();
        check("andi_b", bus.ex_b, 32'h0000_8001);
        check("andi_op", bus.ex_op, 4'b0000);
        check("andi_dest", bus.ex_dest, 11);
        check("andi_ctrl", ctrl(), 5'b10000);

        // addi sign-extends
        set_instr(6'h08, 6'h00, 32'h55, 32'hDEAD, 16'h8001, 5'd12, 5'd30, 32'h20);
        issue();
        check("addi_b", bus.ex_b, 32'hFFFF_8001);
        check("addi_op", bus.ex_op, 4'b0010);
        check("addi_ov", bus.ex_ov_en, 1);

        // ori zero-extends
        set_instr(6'h0D, 6'h00, 0, 0, 16'hFFFF, 5'd1, 5'd0, 32'h24);
        issue();
        check("ori_b", bus.ex_b, 32'h0000_FFFF);
        check("ori_op", bus.ex_op, 4'b0001);

        // slti
        set_instr(6'h0A, 6'h00, 0, 0, 16'hFFFE, 5'd2, 5'd0, 32'h28);
        issue();
        check("slti_op", bus.ex_op, 4'b0111);
        check("slti_sub", bus.ex_sub, 1);
        check("slti_b", bus.ex_b, 32'hFFFF_FFFE);

        // bne uses rt_val as B
        set_instr(6'h05, 6'h00, 32'hA, 32'hB, 16'h0040, 5'd2, 5'd0, 32'h2C);
        issue();
        check("bne_op", bus.ex_op, 4'b0110);
        check("bne_sub", bus.ex_sub, 1);
        check("bne_b", bus.ex_b, 32'hB);
        check("bne_ctrl", ctrl(), 5'b00011);

        // lw / sw
        set_instr(6'h23, 6'h00, 32'h1000, 0, 16'hFFFC, 5'd8, 5'd0, 32'h30);
        issue();
        check("lw_ctrl", ctrl(), 5'b11000);
        check("lw_b", bus.ex_b, 32'hFFFF_FFFC);
        set_instr(6'h2B, 6'h00, 32'h1000, 0, 16'h0004, 5'd8, 5'd0, 32'h34);
        issue();
        check("sw_ctrl", ctrl(), 5'b00100);
        check("sw_op", bus.ex_op, 4'b0010);

        // Illegal: xori and R-type funct 0x26
        set_instr(6'h0E, 6'h00, 1, 2, 16'h1234, 5'd3, 5'd4, 32'h38);
        issue();
        check("xori_illegal", bus.ex_illegal, 1);
        check("xori_op", bus.ex_op, 4'b0010);
        check("xori_ctrl", ctrl(), 0);
        check("xori_subov", {bus.ex_sub, bus.ex_ov_en}, 0);
        set_instr(6'h00, 6'h26, 1, 2, 16'h0, 5'd3, 5'd4, 32'h3C);
        issue();
        check("xor_illegal", bus.ex_illegal, 1);
        check("xor_op", bus.ex_op, 4'b0010);
        check("xor_ctrl", ctrl(), 0);
        check("xor_subov", {bus.ex_sub, bus.ex_ov_en}, 0);
        set_instr(6'h00, 6'h21, 1, 2, 16'h0, 5'd3, 5'd4, 32'h40);
        issue();
        check("addu_illegal_clear", bus.ex_illegal, 0);
        step();
        check("drain_valid", bus.ex_valid, 0);

        // Backpressure: 4 addiu (imm = index), 3 stall cycles on the 2nd
        sent       = 0;
        got        = 0;
        stall_left = 3;
        stall_seen = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            if (bus.ex_valid && bus.ex_pc == PC_BASE + 4 && stall_left > 0) begin
                bus.ex_ready = 1'b0;
                stall_left--;
            end else begin
                bus.ex_ready = 1'b1;
            end
            if (sent < 4) begin
                set_instr(6'h09, 6'h00, 0, 0, 16'(sent), 5'd7, 5'd0, PC_BASE + 32'(4 * sent));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.ex_ready) begin
                stall_seen++;
                check("bp_in_ready", bus.in_ready, 0);
                check("bp_hold_pc", bus.ex_pc, PC_BASE + 4);
                check("bp_hold_b", bus.ex_b, 1);
            end
            if (bus.ex_valid && bus.ex_ready) begin
                check("bp_order_pc", bus.ex_pc, PC_BASE + 32'(4 * got));
                check("bp_order_b", bus.ex_b, 32'(got));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b1;
        check("bp_delivered", 32'(got), 4);
        check("bp_stall_cycles", 32'(stall_seen), 3);
        step();
        check("bp_drained", bus.ex_valid, 0);

        // Flush coinciding with a load while ex_valid=1
        bus.ex_ready = 1'b0;
        set_instr(6'h09, 6'h00, 0, 0, 16'h1, 5'd1, 5'd0, 32'h200);
        issue();
        check("fl_held_valid", bus.ex_valid, 1);
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b1;
        set_instr(6'h09, 6'h00, 0, 0, 16'h2, 5'd1, 5'd0, 32'h204);
        bus.in_valid = 1'b1;
        #1;
        check("fl_in_ready", bus.in_ready, 1);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_valid", bus.ex_valid, 0);
        set_instr(6'h09, 6'h00, 0, 0, 16'h3, 5'd1, 5'd0, 32'h208);
        issue();
        check("fl_next_valid", bus.ex_valid, 1);
        check("fl_next_pc", bus.ex_pc, 32'h208);
        check("fl_next_b", bus.ex_b, 3);

        // Reset asserted mid-transfer, no clock edge needed
        bus.ex_ready = 1'b0;
        set_instr(6'h00, 6'h22, 5, 6, 16'h0, 5'd1, 5'd2, 32'h300);
        bus.in_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.ex_valid, 0);
        check("arst_op", bus.ex_op, 4'b0010);
        check("arst_a", bus.ex_a, 0);
        check("arst_pc", bus.ex_pc, 0);
        check("arst_in_ready", bus.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        set_instr(6'h00, 6'h24, 32'hF, 32'h3, 16'h0, 5'd1, 5'd2, 32'h304);
        step();
        bus.in_valid = 1'b0;
        check("arst_first_valid", bus.ex_valid, 1);
        check("arst_first_pc", bus.ex_pc, 32'h304);
        check("arst_first_op", bus.ex_op, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that feeds the 32-bit ALU. It accepts one decoded instruction per cycle from the decode stage, translates opcode/funct into the ALU's 4-bit operation select plus subtract/overflow controls, and selects the B operand (register, sign-extended or zero-extended immediate). It registers everything for the execute stage behind a valid/ready handshake, with stall and flush support.

## Interface
- DATA_W, 32, operand width; fixed at 32 for MIPS.
- PC_W, 32, width of the carried program counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  6  instruction bits [31:26].
- in_funct  in  6  instruction bits [5:0].
- in_rs_val, in_rt_val  in  DATA_W  register-file read data (already forwarded upstream).
- in_imm  in  16  instruction bits [15:0].
- in_rt, in_rd  in  5  register specifiers.
- in_pc  in  PC_W  PC+4 of the instruction.
- flush  in  1  kill the held instruction and any instruction accepted this cycle.
- ex_valid  out  1  execute-stage payload valid.
- ex_ready  in  1  execute stage consumes the payload this cycle.
- ex_op  out  4  ALU select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- ex_sub  out  1  invert B and force carry-in 1 (SUB, SLT, branch compare).
- ex_ov_en  out  1  signed overflow trap enabled (add, sub, addi).
- ex_a, ex_b  out  DATA_W  ALU operands.
- ex_dest  out  5  write-back register (rd for R-type, rt for I-type).
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne  out  1  control bits.
- ex_illegal  out  1  unsupported encoding.
- ex_pc  out  PC_W  carried PC+4.

## Operation
- Decode, R-type (opcode 0x00), by funct: 0x20 add → ADD, ov_en; 0x21 addu → ADD; 0x22 sub → SUB, sub, ov_en; 0x23 subu → SUB, sub; 0x24 and → AND; 0x25 or → OR; 0x27 nor → NOR; 0x2A slt → SLT, sub. All of these set reg_write, dest=rd and B=rs_val's partner rt_val.
- Decode, I-type, with B=immediate and dest=rt:
  - 0x08 addi → ADD, ov_en, sign-extended.
  - 0x09 addiu → ADD, sign-extended.
  - 0x0A slti → SLT, sub, sign-extended.
  - 0x0C andi → AND, zero-extended.
  - 0x0D ori → OR, zero-extended.
  - 0x23 lw → ADD, sign-extended, mem_read, reg_write.
  - 0x2B sw → ADD, sign-extended, mem_write, no reg_write.
  - 0x04 beq → SUB, sub, B=rt_val, branch, no reg_write.
  - 0x05 bne → as beq plus branch_ne.
- reg_write is set for every R-type and for addi, addiu, slti, andi, ori and lw; it is clear for sw, beq and bne.
- Any other opcode/funct: ex_illegal=1, op=ADD, sub=0, ov_en=0, and all of reg_write, mem_read, mem_write and branch forced to 0.
- ex_a = in_rs_val always.
- Unused controls are 0. ex_sub=1 exactly when op is SUB or SLT.
- Single-entry register; there is no skid buffer.
- in_ready = !ex_valid || ex_ready. It is purely combinational and does not depend on in_valid.
- Load: in_valid && in_ready.
  - Payload captured, ex_valid←1.
  - Otherwise, if ex_ready, ex_valid←0.
  - Otherwise payload and ex_valid hold unchanged.
- flush has priority over load and hold: ex_valid←0 next edge. Payload registers may update but must not be observed.
- When a flush coincides with a load, the incoming instruction is discarded. in_ready still follows the rule above, so the upstream stage treats it as consumed.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at ex_* after edge N and valid until consumed.
- Throughput is 1 instruction/cycle while ex_ready=1.
- While ex_valid && !ex_ready, all ex_* outputs are held stable.
- Reset (rst_n=0, asynchronous, immediate):
  - ex_valid=0 and ex_illegal=0.
  - All control bits are 0, ex_op=0010, ex_a=ex_b=0, ex_dest=0, ex_pc=0.
  - in_ready=1.
- When reset is released mid-stream, the first edge with rst_n=1 may accept an instruction. Any instruction in flight at reset assertion is lost with no partial output.

## Test plan
- Reset: assert rst_n=0 mid-transfer → ex_valid=0, ex_op=0010 immediately without a clock edge; after release, in_ready=1.
- R-type sweep: opcode 0, funct 0x22, rs=7, rt=3, rd=9 → next cycle ex_op=0110, ex_sub=1, ex_ov_en=1, ex_a=7, ex_b=3, ex_dest=9, ex_reg_write=1.
- Immediates: andi imm=0x8001 → ex_b=0x00008001; addi imm=0x8001 → ex_b=0xFFFF8001; slti → op 0111, sub 1; bne → op 0110, branch 1, branch_ne 1, reg_write 0.
- Backpressure: stream 4 instructions with ex_ready low for 3 cycles on the 2nd → in_ready=0 for those cycles, ex_* stable, all 4 delivered in order, none duplicated.
- Flush: flush on the same cycle as a load while ex_valid=1 → next cycle ex_valid=0; the following instruction is delivered normally.
- Illegal: opcode 0x0E (xori) and R-type funct 0x26 → ex_illegal=1, ex_op=0010, all control bits 0.
